// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Iterative AES encryption engine: one 128-bit state register, one full
// round per clock. Round keys are fetched from an external key store that
// this block addresses through outKeyIdx; the store must return the key
// combinationally in the same cycle.
//
// Ports:
//   inClk       clock, rising edge
//   inRst       asynchronous active-high reset
//   inValid     input block valid
//   outReady    block can accept a new input (IDLE only)
//   inData      plaintext, byte 0 at [127:120]
//   outKeyIdx   round-key index requested this cycle
//   inRoundKey  round key for outKeyIdx
//   outValid    ciphertext valid (DONE)
//   inReady     downstream accepts the ciphertext
//   outData     ciphertext (the state register)
//   outBusy     high in ROUND or DONE
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 14,
    parameter int KEY_IDX_W  = 4
) (
    input  logic                 inClk,
    input  logic                 inRst,
    input  logic                 inValid,
    output logic                 outReady,
    input  logic [127:0]         inData,
    output logic [KEY_IDX_W-1:0] outKeyIdx,
    input  logic [127:0]         inRoundKey,
    output logic                 outValid,
    input  logic                 inReady,
    output logic [127:0]         outData,
    output logic                 outBusy
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    localparam logic [KEY_IDX_W-1:0] LAST_ROUND = KEY_IDX_W'(NUM_ROUNDS);

    fsm_t                 fsm_q, fsm_d;
    logic [KEY_IDX_W-1:0] round_q, round_d;
    logic [127:0]         state_q, state_d;
    logic [127:0]         sr_out, mc_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] term;
        acc  = 8'h00;
        term = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ term;
            term = xtime(term);
        end
        return acc;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254, zero maps to zero) followed
    // by the affine transform; a^254 is the product of a^2, a^4, ... a^128.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox(s[8*i +: 8]);
        return r;
    endfunction

    // Byte n sits at row n%4, column n/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = s[127-8*(row+4*((c+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    always_comb begin
        sr_out = shift_rows(sub_bytes(state_q));
        mc_out = mix_columns(sr_out);
    end

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            state_q <= state_d;
        end
    end

    // outKeyIdx decodes registered state only, so the key store sees no
    // combinational path from inValid. In IDLE it presents key 0 for the
    // initial AddRoundKey performed at acceptance.
    always_comb begin
        fsm_d     = fsm_q;
        round_d   = round_q;
        state_d   = state_q;
        outReady  = 1'b0;
        outValid  = 1'b0;
        outKeyIdx = '0;
        case (fsm_q)
            IDLE: begin
                outReady = 1'b1;
                if (inValid) begin
                    state_d = inData ^ inRoundKey;
                    round_d = KEY_IDX_W'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                outKeyIdx = round_q;
                if (round_q == LAST_ROUND) begin
                    // Final round skips MixColumns.
                    state_d = sr_out ^ inRoundKey;
                    round_d = '0;
                    fsm_d   = DONE;
                end else begin
                    state_d = mc_out ^ inRoundKey;
                    round_d = round_q + KEY_IDX_W'(1);
                end
            end
            DONE: begin
                outValid = 1'b1;
                if (inReady) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign outData = state_q;
    assign outBusy = (fsm_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer. Two instances share the
// clock and reset: an AES-256 build (14 rounds) and an AES-128 build
// (10 rounds). The bench acts as the key-expansion store, expanding keys
// with its own table-built S-box. Expected ciphertexts are published test
// vectors, pushed into a per-instance queue at acceptance and popped by a
// monitor at each output handshake.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         inRst;
    logic         drvValid, drvReady;
    logic [127:0] drvData;
    bit           sel10;

    logic         inValid14, outReady14, outValid14, inReady14, outBusy14;
    logic [3:0]   outKeyIdx14;
    logic [127:0] inRoundKey14, outData14;
    logic         inValid10, outReady10, outValid10, inReady10, outBusy10;
    logic [3:0]   outKeyIdx10;
    logic [127:0] inRoundKey10, outData10;

    logic         selReady, selValid, selBusy;
    logic [3:0]   selKeyIdx;
    logic [127:0] selData;

    logic [127:0] rk14 [0:15];
    logic [127:0] rk10 [0:15];
    logic [31:0]  kw [0:59];
    logic [7:0]   sbox [0:255];

    logic [127:0] expQ14 [$];
    logic [127:0] expQ10 [$];

    int total = 0;
    int bad = 0;
    int cycleCount = 0;

    bit           prevValid [2];
    bit           prevReady [2];
    logic [127:0] prevData [2];

    localparam logic [255:0] KEY_C3 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_SP =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [127:0] spPt [4] = '{128'h6bc1bee22e409f96e93d7e117393172a,
                               128'hae2d8a571e03ac9c9eb76fac45af8e51,
                               128'h30c81c46a35ce411e5fbc1191a0a52ef,
                               128'hf69f2445df4f9b17ad2b417be66c3710};
    logic [127:0] spCt [4] = '{128'hf3eed1bdb5d2a03c064b5a7e3db181f8,
                               128'h591ccb10d410ed26dc5ba74a31362870,
                               128'hb6ed21b99ca6f4f9f153e7b1beafed1d,
                               128'h23304b7a39f9f3ff067d8d8f9e24ecc7};

    assign inValid14    = drvValid & ~sel10;
    assign inReady14    = sel10 ? 1'b1 : drvReady;
    assign inValid10    = drvValid & sel10;
    assign inReady10    = sel10 ? drvReady : 1'b1;
    assign inRoundKey14 = rk14[outKeyIdx14];
    assign inRoundKey10 = rk10[outKeyIdx10];

    assign selReady  = sel10 ? outReady10  : outReady14;
    assign selValid  = sel10 ? outValid10  : outValid14;
    assign selBusy   = sel10 ? outBusy10   : outBusy14;
    assign selKeyIdx = sel10 ? outKeyIdx10 : outKeyIdx14;
    assign selData   = sel10 ? outData10   : outData14;

    aes_round_sequencer #(.NUM_ROUNDS(14), .KEY_IDX_W(4)) dut14 (
        .inClk(clk), .inRst(inRst), .inValid(inValid14), .outReady(outReady14),
        .inData(drvData), .outKeyIdx(outKeyIdx14), .inRoundKey(inRoundKey14),
        .outValid(outValid14), .inReady(inReady14), .outData(outData14),
        .outBusy(outBusy14));

    aes_round_sequencer #(.NUM_ROUNDS(10), .KEY_IDX_W(4)) dut10 (
        .inClk(clk), .inRst(inRst), .inValid(inValid10), .outReady(outReady10),
        .inData(drvData), .outKeyIdx(outKeyIdx10), .inRoundKey(inRoundKey10),
        .outValid(outValid10), .inReady(inReady10), .outData(outData10),
        .outBusy(outBusy10));

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timeout waiting for DUT", name);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box table built by walking generator 3 and its inverse together.
    task automatic buildSbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expandKey(input logic [255:0] key, input int nk, input int nr,
                             input bit to10);
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) kw[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = kw[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            kw[i] = kw[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (to10) rk10[r] = (r <= nr) ? {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]} : '0;
            else      rk14[r] = (r <= nr) ? {kw[4*r], kw[4*r+1], kw[4*r+2], kw[4*r+3]} : '0;
        end
    endtask

    // Monitor step for one instance: data/valid must hold under
    // backpressure, and every handshake pops one expected ciphertext.
    task automatic monitorStep(input int which, input logic valid, input logic ready,
                               input logic [127:0] data);
        logic [127:0] expect_v;
        bit           empty;
        if (prevValid[which] && !prevReady[which]) begin
            checkOutput("hold valid", 128'(valid), 128'd1);
            checkOutput("hold data", data, prevData[which]);
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            empty = (which == 0) ? (expQ14.size() == 0) : (expQ10.size() == 0);
            if (empty) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected output d%0d: actual=%h required=none", which, data);
            end else begin
                if (which == 0) expect_v = expQ14.pop_front();
                else            expect_v = expQ10.pop_front();
                checkOutput("ciphertext", data, expect_v);
            end
        end
        prevValid[which] = (valid === 1'b1);
        prevReady[which] = (ready === 1'b1);
        prevData[which]  = data;
    endtask

    always begin
        @(negedge clk);
        #2;
        monitorStep(0, outValid14, inReady14, outData14);
        monitorStep(1, outValid10, inReady10, outData10);
    end

    task automatic checkResetState();
        checkOutput("reset valid", 128'(selValid), 128'd0);
        checkOutput("reset busy", 128'(selBusy), 128'd0);
        checkOutput("reset ready", 128'(selReady), 128'd1);
        checkOutput("reset key index", 128'(selKeyIdx), 128'd0);
        checkOutput("reset data", selData, 128'd0);
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] ct,
                                 input bit keepValid, output int acceptEdge);
        int w;
        w = 0;
        drvData  = pt;
        drvValid = 1'b1;
        while (selReady !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (selReady !== 1'b1) begin
            reportTimeout("accept");
            drvValid   = 1'b0;
            acceptEdge = cycleCount;
            return;
        end
        checkOutput("idle key index", 128'(selKeyIdx), 128'd0);
        if (sel10) expQ10.push_back(ct);
        else       expQ14.push_back(ct);
        acceptEdge = cycleCount + 1;
        @(negedge clk);
        if (!keepValid) drvValid = 1'b0;
    endtask

    task automatic runSingle(input logic [127:0] pt, input logic [127:0] ct,
                             input int nr, input int hold);
        int acceptEdge;
        int k;
        drvReady = (hold == 0);
        applyStimulus(pt, ct, 1'b0, acceptEdge);
        k = 0;
        while (selValid !== 1'b1 && k < 3 * nr) begin
            checkOutput("key index", 128'(selKeyIdx), 128'(cycleCount - acceptEdge + 1));
            checkOutput("round busy", 128'(selBusy), 128'd1);
            @(negedge clk);
            k++;
        end
        if (selValid !== 1'b1) begin
            reportTimeout("output valid");
            drvReady = 1'b1;
            return;
        end
        checkOutput("latency", 128'(cycleCount - acceptEdge), 128'(nr));
        checkOutput("done key index", 128'(selKeyIdx), 128'd0);
        for (int i = 0; i < hold; i++) begin
            checkOutput("backpressure valid", 128'(selValid), 128'd1);
            checkOutput("backpressure ready", 128'(selReady), 128'd0);
            @(negedge clk);
        end
        drvReady = 1'b1;
        @(negedge clk);
        checkOutput("idle ready", 128'(selReady), 128'd1);
        checkOutput("idle valid", 128'(selValid), 128'd0);
        checkOutput("idle busy", 128'(selBusy), 128'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int acceptEdge;
        int edges [4];
        int w;
        inRst    = 1'b0;
        drvValid = 1'b0;
        drvReady = 1'b1;
        drvData  = '0;
        sel10    = 1'b0;
        buildSbox();
        expandKey(KEY_C3, 8, 14, 1'b0);
        expandKey({KEY_C1, 128'h0}, 4, 10, 1'b1);

        #1 inRst = 1'b1;
        repeat (2) @(negedge clk);
        checkResetState();
        sel10 = 1'b1;
        #1;
        checkResetState();
        sel10 = 1'b0;
        @(negedge clk);
        inRst = 1'b0;
        @(negedge clk);

        $display("[TB] FIPS-197 C.3 with 20 cycles of backpressure");
        runSingle(PT_FIPS, CT_C3, 14, 20);

        $display("[TB] back-to-back blocks");
        expandKey(KEY_SP, 8, 14, 1'b0);
        drvReady = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(spPt[i], spCt[i], 1'b1, edges[i]);
        drvValid = 1'b0;
        for (int i = 1; i < 4; i++)
            checkOutput("accept spacing", 128'(edges[i] - edges[i-1]), 128'd16);
        w = 0;
        while ((expQ14.size() != 0 || selBusy !== 1'b0) && w < 100) begin
            @(negedge clk);
            w++;
        end
        checkOutput("back-to-back drained", 128'(expQ14.size()), 128'd0);

        $display("[TB] reset at round 7");
        expandKey(KEY_C3, 8, 14, 1'b0);
        applyStimulus(128'hffeeddccbbaa99887766554433221100, 128'h0, 1'b0, acceptEdge);
        w = 0;
        while (selKeyIdx !== 4'd7 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (selKeyIdx !== 4'd7) reportTimeout("round 7");
        inRst = 1'b1;
        #1;
        checkResetState();
        expQ14.delete();
        @(negedge clk);
        inRst = 1'b0;
        @(negedge clk);
        runSingle(PT_FIPS, CT_C3, 14, 0);

        $display("[TB] inValid during ROUND and DONE");
        drvReady = 1'b0;
        applyStimulus(PT_FIPS, CT_C3, 1'b0, acceptEdge);
        repeat (5) @(negedge clk);
        drvData  = 128'hdeadbeefcafef00d0123456789abcdef;
        drvValid = 1'b1;
        @(negedge clk);
        drvValid = 1'b0;
        w = 0;
        while (selValid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (selValid !== 1'b1) reportTimeout("output valid");
        drvData  = 128'h0f0e0d0c0b0a09080706050403020100;
        drvValid = 1'b1;
        repeat (2) @(negedge clk);
        drvValid = 1'b0;
        checkOutput("done ready", 128'(selReady), 128'd0);
        drvReady = 1'b1;
        @(negedge clk);
        checkOutput("idle valid", 128'(selValid), 128'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("no extra block", 128'(selBusy), 128'd0);
        end
        checkOutput("queue empty", 128'(expQ14.size()), 128'd0);

        $display("[TB] NUM_ROUNDS=10, FIPS-197 C.1");
        sel10 = 1'b1;
        #1;
        @(negedge clk);
        runSingle(PT_FIPS, CT_C1, 10, 0);
        checkOutput("queue empty 10", 128'(expQ10.size()), 128'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES encryption round controller and datapath. It holds one 128-bit state register and applies one AES round per clock.
- Each round uses the team's combinational SubBytes, ShiftRows, MixColumns and AddRoundKey function blocks.
- Round keys come from an external key store, addressed by this block. The block sits between the XTS tweak/data path and the key-expansion store.
- It has a ready/valid handshake on both the input and the output side.

Parameters:
- NUM_ROUNDS, 14, number of AES rounds. Legal values are 10, 12 and 14; the default of 14 is AES-256.
- KEY_IDX_W, 4, width of the round-key index. It must satisfy 2^KEY_IDX_W > NUM_ROUNDS.

Ports:
- inClk  input  1  clock; all state updates on the rising edge.
- inRst  input  1  asynchronous, active-high reset.
- inValid  input  1  input block valid.
- outReady  output  1  block can accept a new input.
- inData  input  128  plaintext block; byte 0 is at [127:120].
- outKeyIdx  output  KEY_IDX_W  index of the round key required this cycle.
- inRoundKey  input  128  round key for outKeyIdx. It must be valid combinationally in the same cycle.
- outValid  output  1  ciphertext valid.
- inReady  input  1  downstream accepts the ciphertext.
- outData  output  128  ciphertext, equal to the state register.
- outBusy  output  1  high in ROUND or DONE.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FSM goes to IDLE; round counter = 0; state register = 0.
  - Outputs: outValid=0, outBusy=0, outReady=1, outKeyIdx=0, outData=0.
  - Any block in flight is discarded silently.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - outReady=1, outKeyIdx=0.
  - On inValid&&outReady: state <= inData ^ inRoundKey (initial AddRoundKey); round <= 1; go to ROUND.
  - inData is captured only at this edge; it may change afterwards.
- ROUND:
  - outReady=0, outKeyIdx=round.
  - For round < NUM_ROUNDS: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), inRoundKey); round <= round+1.
  - For round == NUM_ROUNDS (final round): MixColumns is bypassed; go to DONE.
  - inValid is ignored.
- DONE:
  - outValid=1, outData=state, outKeyIdx=0.
  - State is held stable while inReady=0, with no timeout.
  - On inReady: go to IDLE (outValid drops the next cycle).
  - A new block cannot be accepted in the same cycle as the output handshake.
- Latency: with acceptance at edge E, outValid is high after edge E+NUM_ROUNDS (14 cycles for AES-256).
- Throughput: with inReady tied high, at most one block per NUM_ROUNDS+2 cycles (16 for AES-256).
- Round counter is KEY_IDX_W bits wide. It never exceeds NUM_ROUNDS and has no wrap.
- outKeyIdx is a registered-state decode only; it has no combinational path from inValid.
- Rounds 1..NUM_ROUNDS request each key index exactly once per block, in ascending order.
- The output handshake uses standard valid/ready. outData must not change while outValid=1 and inReady=0.
- Simultaneous events:
  - inValid high while outValid is pending: ignored.
  - Reset asserted together with a handshake: reset wins.
- outBusy = (FSM != IDLE).

Test Plan:
- FIPS-197 C.3 vector: plaintext 00112233445566778899aabbccddeeff, key 000102…1f, round keys from the reference model. Required: outData = 8ea2b7ca516745bfeafc49904b496089, outValid rises exactly 14 cycles after acceptance, and outKeyIdx sequence is 0,1,…,14.
- Backpressure: hold inReady=0 for 20 cycles in DONE. Required: outData stable and outValid=1 throughout; outReady=0. Then raise inReady. Required: IDLE and outReady=1 on the next cycle.
- Back-to-back blocks: inValid tied high, inReady tied high, 4 random blocks. Required: acceptances 16 cycles apart and all ciphertexts matching the model.
- Reset mid-operation: assert inRst at round 7 for one cycle. Required: outputs immediately at reset values; the next accepted block encrypts correctly with no residue from the aborted block.
- inValid during ROUND/DONE: pulse inValid with a different inData. Required: ignored; the current block's result is unchanged; no extra block is produced.
- NUM_ROUNDS=10 build, FIPS-197 C.1 vector (key 000102…0f). Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a after 10 cycles.
